// File: rtl/commit_controller_pkg.sv
// rtl/commit_controller_pkg.sv - shared constants, types and state encodings for the commit controller
package commit_controller_pkg;

  // Commit FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_ROLLBACK   = 2'd2
  } state_t;

  localparam int DEF_ROB_ID_W = 4;

  typedef logic [DEF_ROB_ID_W-1:0] rob_id_type;
  typedef logic [31:0]             data_type;
  typedef logic [4:0]              reg_pos_type;

  // Tag 0 means "no producer"; register 0 is never written
  localparam rob_id_type  ZERO_ROB  = '0;
  localparam reg_pos_type ZERO_REG  = '0;
  localparam data_type    ZERO_WORD = '0;

endpackage

// File: rtl/commit_controller.sv
// rtl/commit_controller.sv - in-order ROB head retirement, store handshake and mispredict rollback
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_ID_W     = DEF_ROB_ID_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                head_valid,
  input  logic                head_ready,
  input  logic [4:0]          head_rd,
  input  logic [ROB_ID_W-1:0] head_rob_id,
  input  logic [31:0]         head_value,
  input  logic                head_is_store,
  input  logic                head_mispredict,
  input  logic [31:0]         head_target_pc,
  input  logic                store_ack,
  output logic                pop_head,
  output logic                commit_flag,
  output logic [4:0]          rd_to_rf,
  output logic [ROB_ID_W-1:0] Q_to_rf,
  output logic [31:0]         V_to_rf,
  output logic                store_commit_req,
  output logic                rollback_flag,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         commit_count
);

  // Wide enough to hold FLUSH_CYCLES even when it is 0 or 1
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 2);

  state_t               state_q, state_d;
  logic                 pop_d, commit_d, rollback_d, redirect_valid_d, store_req_d;
  reg_pos_type          rd_d;
  logic [ROB_ID_W-1:0]  q_d;
  data_type             v_d, redirect_pc_d, count_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;

  // Next-state and next-output decode; head is ignored while the previous pop is still visible
  always_comb begin
    state_d          = state_q;
    pop_d            = 1'b0;
    commit_d         = 1'b0;
    rollback_d       = 1'b0;
    redirect_valid_d = 1'b0;
    store_req_d      = store_commit_req;
    rd_d             = rd_to_rf;
    q_d              = Q_to_rf;
    v_d              = V_to_rf;
    redirect_pc_d    = redirect_pc;
    flush_d          = flush_q;

    case (state_q)
      ST_IDLE: begin
        if (!pop_head && head_valid && head_ready) begin
          if (head_mispredict) begin
            pop_d            = 1'b1;
            commit_d         = 1'b1;
            rollback_d       = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = head_target_pc;
            rd_d             = head_rd;
            q_d              = head_rob_id;
            v_d              = head_value;
            if (FLUSH_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ROLLBACK;
              flush_d = FLUSH_W'(FLUSH_CYCLES);
            end
          end else if (head_is_store) begin
            store_req_d = 1'b1;
            state_d     = ST_WAIT_STORE;
          end else begin
            pop_d    = 1'b1;
            commit_d = 1'b1;
            rd_d     = head_rd;
            q_d      = head_rob_id;
            v_d      = head_value;
          end
        end
      end
      ST_WAIT_STORE: begin
        if (store_ack) begin
          store_req_d = 1'b0;
          pop_d       = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ROLLBACK: begin
        if (flush_q <= FLUSH_W'(1)) begin
          flush_d = '0;
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_q - FLUSH_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        store_req_d = 1'b0;
        flush_d     = '0;
      end
    endcase

    count_d = commit_count + 32'(pop_d);
  end

  // Registered state and outputs; a low rdy freezes everything and only drops the pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      pop_head         <= 1'b0;
      commit_flag      <= 1'b0;
      rollback_flag    <= 1'b0;
      redirect_valid   <= 1'b0;
      store_commit_req <= 1'b0;
      rd_to_rf         <= ZERO_REG;
      Q_to_rf          <= ROB_ID_W'(ZERO_ROB);
      V_to_rf          <= ZERO_WORD;
      redirect_pc      <= ZERO_WORD;
      commit_count     <= ZERO_WORD;
      flush_q          <= '0;
    end else if (!rdy) begin
      pop_head         <= 1'b0;
      commit_flag      <= 1'b0;
      rollback_flag    <= 1'b0;
      redirect_valid   <= 1'b0;
    end else begin
      state_q          <= state_d;
      pop_head         <= pop_d;
      commit_flag      <= commit_d;
      rollback_flag    <= rollback_d;
      redirect_valid   <= redirect_valid_d;
      store_commit_req <= store_req_d;
      rd_to_rf         <= rd_d;
      Q_to_rf          <= q_d;
      V_to_rf          <= v_d;
      redirect_pc      <= redirect_pc_d;
      commit_count     <= count_d;
      flush_q          <= flush_d;
    end
  end

endmodule

// File: tb/tb_commit_controller.sv
// tb/tb_commit_controller.sv - scoreboard bench for commit_controller
module tb_commit_controller;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        head_valid;
  logic        head_ready;
  logic [4:0]  head_rd;
  logic [3:0]  head_rob_id;
  logic [31:0] head_value;
  logic        head_is_store;
  logic        head_mispredict;
  logic [31:0] head_target_pc;
  logic        store_ack;
  logic        pop_head;
  logic        commit_flag;
  logic [4:0]  rd_to_rf;
  logic [3:0]  Q_to_rf;
  logic [31:0] V_to_rf;
  logic        store_commit_req;
  logic        rollback_flag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] commit_count;

  commit_controller #(.ROB_ID_W(4), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .head_valid       (head_valid),
    .head_ready       (head_ready),
    .head_rd          (head_rd),
    .head_rob_id      (head_rob_id),
    .head_value       (head_value),
    .head_is_store    (head_is_store),
    .head_mispredict  (head_mispredict),
    .head_target_pc   (head_target_pc),
    .store_ack        (store_ack),
    .pop_head         (pop_head),
    .commit_flag      (commit_flag),
    .rd_to_rf         (rd_to_rf),
    .Q_to_rf          (Q_to_rf),
    .V_to_rf          (V_to_rf),
    .store_commit_req (store_commit_req),
    .rollback_flag    (rollback_flag),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .commit_count     (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        commit;
    logic        pop;
    logic        rollback;
    logic        redirect;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  q;
    logic [31:0] v;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;
  logic prev_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  task automatic push_exp(input logic c, input logic p, input logic rb, input logic rv,
                          input logic [31:0] pc, input logic [4:0] rd, input logic [3:0] q,
                          input logic [31:0] v, input logic [31:0] cnt);
    exp_t x;
    x.commit = c; x.pop = p; x.rollback = rb; x.redirect = rv;
    x.pc = pc; x.rd = rd; x.q = q; x.v = v; x.count = cnt;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v,
                          input logic st, input logic mp, input logic [31:0] pc);
    head_valid = 1'b1; head_ready = 1'b1;
    head_rd = rd; head_rob_id = id; head_value = v;
    head_is_store = st; head_mispredict = mp; head_target_pc = pc;
  endtask

  // Monitor: every cycle showing a pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (pop_head || commit_flag || rollback_flag || redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got pop=%0b commit=%0b rollback=%0b redirect=%0b expected no event",
                 pop_head, commit_flag, rollback_flag, redirect_valid);
      end else begin
        e = exp_q.pop_front();
        check("ev_commit", 32'(commit_flag), 32'(e.commit));
        check("ev_pop", 32'(pop_head), 32'(e.pop));
        check("ev_rollback", 32'(rollback_flag), 32'(e.rollback));
        check("ev_redirect", 32'(redirect_valid), 32'(e.redirect));
        check("ev_count", commit_count, e.count);
        if (e.commit) begin
          check("ev_rd", 32'(rd_to_rf), 32'(e.rd));
          check("ev_q", 32'(Q_to_rf), 32'(e.q));
          check("ev_v", V_to_rf, e.v);
        end
        if (e.redirect) check("ev_pc", redirect_pc, e.pc);
      end
      check("no_back_to_back_pop", 32'(prev_pop & pop_head), 32'd0);
    end
    prev_pop = pop_head;
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; store_ack = 1'b0;
    head_valid = 1'b0; head_ready = 1'b0; head_rd = '0; head_rob_id = '0; head_value = '0;
    head_is_store = 1'b0; head_mispredict = 1'b0; head_target_pc = '0;
    tick(); tick();
    check("rst_pop", 32'(pop_head), 0);
    check("rst_commit", 32'(commit_flag), 0);
    check("rst_store_req", 32'(store_commit_req), 0);
    check("rst_rollback", 32'(rollback_flag), 0);
    check("rst_redirect", 32'(redirect_valid), 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_rd", 32'(rd_to_rf), 0);
    check("rst_q", 32'(Q_to_rf), 0);
    check("rst_v", V_to_rf, 0);
    check("rst_count", commit_count, 0);
    rst = 1'b1;
    tick();

    // Simple commit
    set_head(5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    push_exp(1, 1, 0, 0, 0, 5'd5, 4'd3, 32'hDEADBEEF, 1);
    tick();
    check("t037_count", commit_count, 1);
    head_valid = 1'b0;
    tick();

    // Head held four cycles: commits on cycles 1 and 3 only
    set_head(5'd7, 4'd4, 32'h12345678, 1'b0, 1'b0, 32'h0);
    push_exp(1, 1, 0, 0, 0, 5'd7, 4'd4, 32'h12345678, 2);
    push_exp(1, 1, 0, 0, 0, 5'd7, 4'd4, 32'h12345678, 3);
    repeat (4) tick();
    head_valid = 1'b0;
    tick();
    check("t038_count", commit_count, 3);

    // Destination x0 still commits
    set_head(5'd0, 4'd9, 32'h00000001, 1'b0, 1'b0, 32'h0);
    push_exp(1, 1, 0, 0, 0, 5'd0, 4'd9, 32'h00000001, 4);
    tick();
    check("rd0_rd", 32'(rd_to_rf), 0);
    head_valid = 1'b0;
    tick();

    // Valid but not ready: nothing happens
    set_head(5'd11, 4'd1, 32'h0000BEEF, 1'b0, 1'b0, 32'h0);
    head_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nready_commit", 32'(commit_flag), 0);
    end
    head_valid = 1'b0;

    // Stray ack in IDLE is ignored
    store_ack = 1'b1;
    tick();
    check("idle_ack_pop", 32'(pop_head), 0);
    store_ack = 1'b0;
    tick();

    // Store with ack arriving after five cycles of request
    set_head(5'd2, 4'd5, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    head_valid = 1'b0; head_is_store = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t039_req_high", 32'(store_commit_req), 1);
      check("t039_no_commit", 32'(commit_flag), 0);
      if (i < 4) tick();
    end
    store_ack = 1'b1;
    push_exp(0, 1, 0, 0, 0, 5'd0, 4'd0, 32'h0, 5);
    tick();
    check("t039_req_low", 32'(store_commit_req), 0);
    store_ack = 1'b0;
    tick();

    // Freeze during WAIT_STORE; ack during freeze is lost
    set_head(5'd3, 4'd6, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    head_valid = 1'b0; head_is_store = 1'b0;
    check("t041_req_on", 32'(store_commit_req), 1);
    rdy = 1'b0; store_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t041_freeze_req", 32'(store_commit_req), 1);
      check("t041_freeze_pop", 32'(pop_head), 0);
    end
    rdy = 1'b1; store_ack = 1'b0;
    tick();
    check("t041_held", 32'(store_commit_req), 1);
    store_ack = 1'b1;
    push_exp(0, 1, 0, 0, 0, 5'd0, 4'd0, 32'h0, 6);
    tick();
    check("t041_done_req", 32'(store_commit_req), 0);
    store_ack = 1'b0;
    tick();

    // Mispredict, then reset in the middle of the rollback
    set_head(5'd1, 4'd7, 32'hCAFE0001, 1'b0, 1'b1, 32'h00001000);
    push_exp(1, 1, 1, 1, 32'h00001000, 5'd1, 4'd7, 32'hCAFE0001, 7);
    tick();
    head_valid = 1'b0; head_mispredict = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("t042_count", commit_count, 0);
    check("t042_pop", 32'(pop_head), 0);
    check("t042_commit", 32'(commit_flag), 0);
    check("t042_rollback", 32'(rollback_flag), 0);
    check("t042_redirect", 32'(redirect_valid), 0);
    check("t042_pc", redirect_pc, 0);
    check("t042_v", V_to_rf, 0);
    check("t042_store_req", 32'(store_commit_req), 0);
    rst = 1'b1;
    set_head(5'd6, 4'd2, 32'h00000077, 1'b0, 1'b0, 32'h0);
    push_exp(1, 1, 0, 0, 0, 5'd6, 4'd2, 32'h00000077, 1);
    tick();
    head_valid = 1'b0;
    tick();

    // Mispredict: two quiet cycles before a ready head is taken
    set_head(5'd1, 4'd7, 32'hCAFE0001, 1'b0, 1'b1, 32'h00001000);
    push_exp(1, 1, 1, 1, 32'h00001000, 5'd1, 4'd7, 32'hCAFE0001, 2);
    tick();
    check("t040_pc", redirect_pc, 32'h00001000);
    set_head(5'd4, 4'd8, 32'h00000055, 1'b0, 1'b0, 32'h0);
    push_exp(1, 1, 0, 0, 0, 5'd4, 4'd8, 32'h00000055, 3);
    tick();
    check("t040_quiet1", 32'(pop_head), 0);
    tick();
    check("t040_quiet2", 32'(pop_head), 0);
    tick();
    check("t040_resume", 32'(pop_head), 1);
    head_valid = 1'b0;
    tick(); tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/commit_controller.md
COMMIT_CONTROLLER -- requirements
Module: commit_controller

Interface
REQ-001 Parameter ROB_ID_W, default 4, width of ROB tag; tag 0 = "no producer" (ZERO_ROB).
REQ-002 Parameter FLUSH_CYCLES, default 2, quiet cycles after rollback before commit resumes.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 rdy  in  1  global ready; low = freeze.
REQ-006 head_valid  in  1  ROB head entry occupied.
REQ-007 head_ready  in  1  head result computed.
REQ-008 head_rd  in  5  head destination register.
REQ-009 head_rob_id  in  ROB_ID_W  head tag.
REQ-010 head_value  in  32  head result.
REQ-011 head_is_store  in  1  head is a store.
REQ-012 head_mispredict  in  1  head is a mispredicted branch/jump.
REQ-013 head_target_pc  in  32  correct PC for mispredict.
REQ-014 store_ack  in  1  LSB finished committed store.
REQ-015 pop_head  out  1  one-cycle pulse, ROB retires head.
REQ-016 commit_flag  out  1  one-cycle pulse to register file.
REQ-017 rd_to_rf / Q_to_rf / V_to_rf  out  5 / ROB_ID_W / 32  commit write data to register file.
REQ-018 store_commit_req  out  1  level, held until store_ack.
REQ-019 rollback_flag  out  1  one-cycle pulse, clears rename tags/RS/LSB.
REQ-020 redirect_valid / redirect_pc  out  1 / 32  pulse plus PC to fetch.
REQ-021 commit_count  out  32  retired-instruction counter.

Function
REQ-022 States IDLE, WAIT_STORE, ROLLBACK; all outputs registered.
REQ-023 IDLE, head_valid & head_ready & !head_is_store: next cycle commit_flag=1, pop_head=1, rd/Q/V = head_rd/head_rob_id/head_value.
REQ-024 Head inputs ignored in any cycle where pop_head=1 (ROB head not yet advanced); max one commit per 2 cycles.
REQ-025 IDLE, ready store at head: store_commit_req=1 next cycle, go WAIT_STORE; no commit_flag for stores.
REQ-026 WAIT_STORE: on store_ack, store_commit_req=0 and pop_head=1 next cycle, go IDLE; no timeout.
REQ-027 Ready head with head_mispredict: same cycle pulses commit_flag, pop_head, rollback_flag, redirect_valid, redirect_pc=head_target_pc; go ROLLBACK.
REQ-028 ROLLBACK: down-counter loaded FLUSH_CYCLES, no head accepted; at zero go IDLE.
REQ-029 head_valid & !head_ready: stay IDLE, all pulses 0.
REQ-030 head_rd=0: commit_flag still pulses, rd_to_rf=0 (register file ignores write).
REQ-031 commit_count +1 on every pop_head pulse, wraps 0xFFFFFFFF->0.
REQ-032 rdy low: state, counters, outputs frozen except pulses forced 0; store_commit_req held.
REQ-033 store_ack outside WAIT_STORE ignored.

Reset
REQ-034 rst low at edge: state IDLE, all pulses 0, store_commit_req 0, rd/Q/V 0, redirect_pc 0, commit_count 0, flush counter 0; reset overrides rdy and mid-store/mid-rollback.

Structure
REQ-035 State encodings, ZERO_ROB, ZERO_REG, ZERO_WORD, ROB_ID_TYPE, DATA_TYPE, REG_POS_TYPE in shared constant header.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Head rd=5,id=3,value=0xDEADBEEF ready -> next cycle commit_flag=1,pop_head=1,rd=5,Q=3,V=0xDEADBEEF; commit_count=1.
REQ-038 Same head held ready 4 cycles, ROB not advancing -> exactly 2 commits (cycles 1,3), never back-to-back.
REQ-039 Store at head, store_ack 5 cycles later -> store_commit_req high 5 cycles, pop_head one cycle after ack, no commit_flag.
REQ-040 Mispredict head target 0x00001000 -> rollback_flag, redirect_valid, commit_flag in one cycle; redirect_pc=0x1000; no pop for 2 following cycles despite ready head.
REQ-041 rdy low 3 cycles during WAIT_STORE, store_ack during freeze ignored -> state held; ack after rdy high completes normally.
REQ-042 rst low during ROLLBACK with commit_count=7 -> next cycle IDLE, commit_count=0, all outputs 0.
